ballot_unit: RTL and testbench
==============================

Name: ballot_unit

Overview:
- Downstream consumer of the voter-authorisation stage's valid_vote pulse.
- Each authorised pulse opens exactly one ballot; the unit then qualifies a single held candidate button and increments that candidate's tally.
- Drives red_led back to the authorisation stage, holding it high while a ballot is open so a second authorisation cannot occur.
- Sits between the authorisation stage and the result display/readout logic.

Parameters:
NUM_CAND, 4, number of candidate buttons (2..8)
CNT_W, 16, width of each candidate tally
HOLD_CYCLES, 50000, consecutive cycles a single candidate button must be held to count as a vote
TIMEOUT_CYCLES, 5000000, cycles an open ballot waits for a vote before expiring

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
valid_vote  input  1  one-cycle authorisation pulse from upstream
cand_button_n  input  NUM_CAND  candidate buttons, active-low (0 = pressed)
red_led  output  1  ballot open/busy; fed back to the authorisation stage
green_led  output  1  ballot open and waiting for a candidate press
vote_accepted  output  1  one-cycle pulse when a tally increments
accepted_cand  output  $clog2(NUM_CAND)  index of the last accepted candidate
ballot_expired  output  1  one-cycle pulse on timeout
tally  output  NUM_CAND*CNT_W  flattened counts; candidate i occupies bits [i*CNT_W +: CNT_W]
total_votes  output  CNT_W+$clog2(NUM_CAND)  sum of accepted votes
overflow  output  1  sticky; set when any tally saturates

Behaviour:
- Reset values: all outputs 0; state IDLE; all tallies and internal counters 0.
- Reset mid-ballot returns the unit to IDLE, clears all tallies, and drops red_led on the next edge.
- All outputs are registered.
- IDLE: red_led=0, green_led=0.
  - valid_vote=1 -> ARMED; red_led=1 and green_led=1 from the next cycle.
  - valid_vote in any other state is ignored.
- ARMED:
  - The timeout counter increments every cycle in ARMED or QUALIFY.
  - Exactly one bit of cand_button_n low -> QUALIFY; latch its index; hold counter=1.
  - Zero or more than one button low -> stay in ARMED.
  - Timeout counter reaching TIMEOUT_CYCLES -> IDLE, ballot_expired pulses for 1 cycle, no tally change.
- QUALIFY:
  - Same single button still low -> increment the hold counter.
  - Button released, or any other button also low -> ARMED; hold counter cleared; timeout counter keeps running.
  - Hold counter reaching HOLD_CYCLES -> RECORD.
  - If timeout and hold completion occur in the same cycle, the vote wins (RECORD).
- RECORD (exactly 1 cycle):
  - Increment the latched candidate's tally and total_votes.
  - vote_accepted=1; accepted_cand=latched index; green_led=0.
  - A tally at 2^CNT_W-1 stays saturated; overflow is set and total_votes is not incremented.
  - Go to RELEASE.
- RELEASE:
  - red_led stays 1 and green_led=0.
  - All cand_button_n high for 1 sampled cycle -> IDLE.
  - This prevents a held button from carrying over into the next ballot.
- Latency: valid_vote to red_led high = 1 cycle. Sustained press to vote_accepted = HOLD_CYCLES+1 cycles after the first low sample.
- tally and total_votes are stable except in the cycle after RECORD.

Decomposition:
- Shared evm package holds:
  - state enum (IDLE, ARMED, QUALIFY, RECORD, RELEASE);
  - default HOLD_CYCLES and TIMEOUT_CYCLES constants, shared with the authorisation stage's 50000-cycle hold;
  - a one-hot-check function (exactly one bit low).
- One natural sub-module: tally_bank — NUM_CAND saturating counters with an increment-enable and index input, producing tally, total_votes and overflow.
- The FSM and timers stay in ballot_unit.

Test Plan:
All scenarios use NUM_CAND=4, CNT_W=4, HOLD_CYCLES=4, TIMEOUT_CYCLES=20.
1. Reset, then valid_vote pulse, then button 2 low for 6 cycles, then release -> red_led high 1 cycle after the pulse; vote_accepted pulses with accepted_cand=2; tally[2]=1, total_votes=1; red_led low 1 cycle after release.
2. Button 1 held without valid_vote for 10 cycles -> no state change; all tallies stay 0; red_led=0.
3. Ballot open, buttons 0 and 3 both low for 10 cycles, then only 3 low for 4 cycles -> vote is rejected while both are low, then tally[3]=1.
4. Ballot open, button 1 low for 3 cycles then released, no further press -> no vote; ballot_expired pulses at cycle 20; tally unchanged; red_led=0.
5. 16 accepted votes for candidate 0 -> tally[0]=15 saturated; overflow=1; total_votes=15.
6. Reset asserted while in QUALIFY with a non-zero tally -> next cycle state is IDLE, all tallies are 0 and red_led=0; a second valid_vote during RELEASE is ignored.

Source files
------------

// File: rtl/ballot_unit_pkg.sv
// Shared ballot definitions: FSM states, default timing constants and the single-press check.
// Hold default matches the authorisation stage's 50000-cycle hold so both stages debounce alike.
package ballot_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_QUALIFY,
        ST_RECORD,
        ST_RELEASE
    } state_t;

    localparam int DEF_HOLD_CYCLES    = 50000;
    localparam int DEF_TIMEOUT_CYCLES = 5000000;
    localparam int MAX_CAND           = 8;

    // Active-low buttons; unused upper positions must be padded with 1 (released).
    function automatic logic exactly_one_low(input logic [MAX_CAND-1:0] btn_n);
        logic [MAX_CAND-1:0] pressed;
        pressed = ~btn_n;
        return (pressed != '0) && ((pressed & (pressed - MAX_CAND'(1))) == '0);
    endfunction

endpackage

// File: rtl/ballot_unit_tally_bank.sv
// Per-candidate saturating vote counters with a running total and sticky overflow flag.
// A saturated candidate's vote is dropped from the total as well as its own tally.
module tally_bank #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 16,
    parameter int IDX_W    = $clog2(NUM_CAND),
    parameter int TOT_W    = CNT_W + $clog2(NUM_CAND)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      inc,
    input  logic [IDX_W-1:0]          idx,
    output logic [NUM_CAND*CNT_W-1:0] tally,
    output logic [TOT_W-1:0]          total_votes,
    output logic                      overflow
);

    logic [CNT_W-1:0] cnt [NUM_CAND];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                cnt[i] <= '0;
            end
            total_votes <= '0;
            overflow    <= 1'b0;
        end else if (inc) begin
            if (cnt[idx] == {CNT_W{1'b1}}) begin
                overflow <= 1'b1;
            end else begin
                cnt[idx]    <= cnt[idx] + CNT_W'(1);
                total_votes <= total_votes + TOT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_flat
        assign tally[g*CNT_W +: CNT_W] = cnt[g];
    end

endmodule

// File: rtl/ballot_unit.sv
// Opens one ballot per authorisation pulse, debounces a single held candidate button and records it.
// red_led holds off further authorisations until the ballot closes and all buttons are released.
module ballot_unit
    import ballot_unit_pkg::*;
#(
    parameter int NUM_CAND       = 4,
    parameter int CNT_W          = 16,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 valid_vote,
    input  logic [NUM_CAND-1:0]                  cand_button_n,
    output logic                                 red_led,
    output logic                                 green_led,
    output logic                                 vote_accepted,
    output logic [$clog2(NUM_CAND)-1:0]          accepted_cand,
    output logic                                 ballot_expired,
    output logic [NUM_CAND*CNT_W-1:0]            tally,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]    total_votes,
    output logic                                 overflow
);

    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW    = $clog2(HOLD_CYCLES + 1);

    state_t            state, state_nxt;
    logic [TW-1:0]     tcnt;
    logic [HW-1:0]     hcnt;
    logic [IDX_W-1:0]  cand_idx;
    logic [IDX_W-1:0]  low_idx;
    logic [MAX_CAND-1:0] btn_pad;
    logic              one_low, same_btn, timeout, held;
    logic              red_d, green_d, accepted_d, expired_d;
    logic [IDX_W-1:0]  accepted_cand_d;

    always_comb begin
        btn_pad                 = '1;
        btn_pad[NUM_CAND-1:0]   = cand_button_n;
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (!cand_button_n[i]) low_idx = IDX_W'(i);
        end
    end

    assign one_low  = exactly_one_low(btn_pad);
    assign same_btn = one_low && (low_idx == cand_idx);
    assign timeout  = (tcnt == TW'(TIMEOUT_CYCLES - 1));
    // hcnt already counts HOLD_CYCLES consecutive low samples, so completion needs no further press.
    assign held     = (hcnt == HW'(HOLD_CYCLES));

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            tcnt           <= '0;
            hcnt           <= '0;
            cand_idx       <= '0;
            red_led        <= 1'b0;
            green_led      <= 1'b0;
            vote_accepted  <= 1'b0;
            ballot_expired <= 1'b0;
            accepted_cand  <= '0;
        end else begin
            state          <= state_nxt;
            tcnt           <= (state == ST_ARMED || state == ST_QUALIFY) ? tcnt + TW'(1) : '0;
            hcnt           <= (state_nxt == ST_QUALIFY) ?
                              ((state == ST_QUALIFY) ? hcnt + HW'(1) : HW'(1)) : '0;
            if (state == ST_ARMED && state_nxt == ST_QUALIFY) cand_idx <= low_idx;
            red_led        <= red_d;
            green_led      <= green_d;
            vote_accepted  <= accepted_d;
            ballot_expired <= expired_d;
            accepted_cand  <= accepted_cand_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (valid_vote) state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (timeout)      state_nxt = ST_IDLE;
                else if (one_low) state_nxt = ST_QUALIFY;
            end
            ST_QUALIFY: begin
                if (held)           state_nxt = ST_RECORD;
                else if (timeout)   state_nxt = ST_IDLE;
                else if (!same_btn) state_nxt = ST_ARMED;
            end
            ST_RECORD:  state_nxt = ST_RELEASE;
            ST_RELEASE: if (&cand_button_n) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        red_d           = (state_nxt != ST_IDLE);
        green_d         = (state_nxt == ST_ARMED) || (state_nxt == ST_QUALIFY);
        accepted_d      = (state == ST_RECORD);
        expired_d       = (state == ST_ARMED || state == ST_QUALIFY) && (state_nxt == ST_IDLE);
        accepted_cand_d = (state == ST_RECORD) ? cand_idx : accepted_cand;
    end

    tally_bank #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W)
    ) u_tally_bank (
        .clock       (clock),
        .reset       (reset),
        .inc         (state == ST_RECORD),
        .idx         (cand_idx),
        .tally       (tally),
        .total_votes (total_votes),
        .overflow    (overflow)
    );

endmodule

// File: tb/tb_ballot_unit.sv
// Directed bench for ballot_unit with short hold/timeout values; cycle-table plus hand sequences.
module tb_ballot_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       valid_vote;
    logic [3:0] cand_button_n;
    logic       red_led, green_led, vote_accepted, ballot_expired, overflow;
    logic [1:0] accepted_cand;
    logic [15:0] tally;
    logic [5:0] total_votes;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       vv;
        logic [3:0] btn;
        logic       red;
        logic       green;
        logic       acc;
        logic       expd;
        logic [5:0] total;
    } vec_t;

    vec_t vecs[$];

    ballot_unit #(
        .NUM_CAND       (4),
        .CNT_W          (4),
        .HOLD_CYCLES    (4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .valid_vote     (valid_vote),
        .cand_button_n  (cand_button_n),
        .red_led        (red_led),
        .green_led      (green_led),
        .vote_accepted  (vote_accepted),
        .accepted_cand  (accepted_cand),
        .ballot_expired (ballot_expired),
        .tally          (tally),
        .total_votes    (total_votes),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic vv, input logic [3:0] btn, input logic r, input logic g,
                       input logic a, input logic e, input logic [5:0] t);
        vec_t v;
        v.vv = vv; v.btn = btn; v.red = r; v.green = g; v.acc = a; v.expd = e; v.total = t;
        vecs.push_back(v);
    endtask

    function automatic logic [3:0] tal(input int c);
        logic [15:0] t;
        t = tally;
        return t[c*4 +: 4];
    endfunction

    task automatic cast_vote(input int c, output int acc_seen);
        acc_seen      = 0;
        valid_vote    = 1'b1;
        tick();
        valid_vote    = 1'b0;
        cand_button_n = 4'hF;
        cand_button_n[c] = 1'b0;
        repeat (4) tick();
        cand_button_n = 4'hF;
        repeat (3) begin
            tick();
            if (vote_accepted) acc_seen++;
        end
    endtask

    initial begin
        int seen;
        reset         = 1'b1;
        valid_vote    = 1'b0;
        cand_button_n = 4'hF;
        repeat (2) tick();
        reset = 1'b0;

        check("rst red", red_led, 0);
        check("rst green", green_led, 0);
        check("rst acc", vote_accepted, 0);
        check("rst exp", ballot_expired, 0);
        check("rst cand", accepted_cand, 0);
        check("rst tally", tally, 0);
        check("rst total", total_votes, 0);
        check("rst ovf", overflow, 0);

        // Scenario 1: candidate 2 held for six cycles, then released.
        add(1, 4'hF, 1, 1, 0, 0, 0);
        repeat (4) add(0, 4'hB, 1, 1, 0, 0, 0);
        add(0, 4'hB, 1, 0, 0, 0, 0);
        add(0, 4'hB, 1, 0, 1, 0, 1);
        add(0, 4'hF, 0, 0, 0, 0, 1);
        // Scenario 2: press without authorisation does nothing.
        repeat (10) add(0, 4'hD, 0, 0, 0, 0, 1);
        add(0, 4'hF, 0, 0, 0, 0, 1);
        // Scenario 3: double press rejected, then candidate 3 alone.
        add(1, 4'hF, 1, 1, 0, 0, 1);
        repeat (10) add(0, 4'h6, 1, 1, 0, 0, 1);
        repeat (4) add(0, 4'h7, 1, 1, 0, 0, 1);
        add(0, 4'hF, 1, 0, 0, 0, 1);
        add(0, 4'hF, 1, 0, 1, 0, 2);
        add(0, 4'hF, 0, 0, 0, 0, 2);
        // Scenario 4: short press released, ballot expires after 20 open cycles.
        add(1, 4'hF, 1, 1, 0, 0, 2);
        repeat (3) add(0, 4'hD, 1, 1, 0, 0, 2);
        repeat (16) add(0, 4'hF, 1, 1, 0, 0, 2);
        add(0, 4'hF, 0, 0, 0, 1, 2);
        add(0, 4'hF, 0, 0, 0, 0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            valid_vote    = vecs[i].vv;
            cand_button_n = vecs[i].btn;
            tick();
            check($sformatf("vec%0d red", i), red_led, vecs[i].red);
            check($sformatf("vec%0d green", i), green_led, vecs[i].green);
            check($sformatf("vec%0d acc", i), vote_accepted, vecs[i].acc);
            check($sformatf("vec%0d exp", i), ballot_expired, vecs[i].expd);
            check($sformatf("vec%0d total", i), total_votes, vecs[i].total);
        end
        check("tbl tally0", tal(0), 0);
        check("tbl tally1", tal(1), 0);
        check("tbl tally2", tal(2), 1);
        check("tbl tally3", tal(3), 1);
        check("tbl cand", accepted_cand, 3);
        check("tbl ovf", overflow, 0);

        // Scenario 5: saturate candidate 0 from a clean reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int v = 1; v <= 16; v++) begin
            cast_vote(0, seen);
            check($sformatf("sat vote%0d acc", v), seen, 1);
            if (v == 15) begin
                check("sat15 tally0", tal(0), 15);
                check("sat15 ovf", overflow, 0);
            end
        end
        check("sat tally0", tal(0), 15);
        check("sat ovf", overflow, 1);
        check("sat total", total_votes, 15);
        check("sat cand", accepted_cand, 0);

        // Scenario 6a: reset while qualifying clears everything at once.
        valid_vote = 1'b1;
        tick();
        valid_vote    = 1'b0;
        cand_button_n = 4'hE;
        repeat (2) tick();
        check("midq red", red_led, 1);
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        cand_button_n = 4'hF;
        check("midrst red", red_led, 0);
        check("midrst green", green_led, 0);
        check("midrst tally", tally, 0);
        check("midrst total", total_votes, 0);
        check("midrst ovf", overflow, 0);
        tick();
        check("midrst idle", red_led, 0);

        // Scenario 6b: authorisation during RELEASE is ignored.
        valid_vote = 1'b1;
        tick();
        valid_vote    = 1'b0;
        cand_button_n = 4'hD;
        repeat (5) tick();
        tick();
        check("rel acc", vote_accepted, 1);
        check("rel cand", accepted_cand, 1);
        valid_vote = 1'b1;
        tick();
        valid_vote = 1'b0;
        check("rel vv red", red_led, 1);
        check("rel vv green", green_led, 0);
        tick();
        cand_button_n = 4'hF;
        tick();
        check("rel done red", red_led, 0);
        repeat (2) tick();
        check("rel ignored red", red_led, 0);
        check("rel ignored green", green_led, 0);
        check("rel tally1", tal(1), 1);
        check("rel total", total_votes, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
